// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits sharing one
// BCD decoder: blank dead-time per slot, double-buffered value, leading-zero blanking.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_suppress,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    frame_tick,
  output logic [1:0]              state_dbg
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, ON = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [DW-1:0]           digit_q, digit_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d, shd_val_q, shd_val_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, shd_dp_q, shd_dp_d;
  logic                    pending_q, pending_d;
  logic                    latch;
  logic                    lead;
  logic [NUM_DIGITS-1:0]   supp;
  logic [3:0]              bcd_d;
  logic [NUM_DIGITS-1:0]   an_n_d;
  logic                    dp_n_d, frame_tick_d;

  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    cnt_d        = cnt_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    shd_val_d    = shd_val_q;
    shd_dp_d     = shd_dp_q;
    pending_d    = pending_q;
    latch        = 1'b0;
    frame_tick_d = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      digit_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          digit_d = '0;
          cnt_d   = '0;
          latch   = 1'b1;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = ON;
        end
        ON: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = BLANK;
            if (digit_q == DIG_LAST) begin
              digit_d      = '0;
              latch        = 1'b1;
              frame_tick_d = 1'b1;
            end else begin
              digit_d = digit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (latch && pending_q) begin
      act_val_d = shd_val_q;
      act_dp_d  = shd_dp_q;
      pending_d = 1'b0;
    end

    // A load landing in the frame-boundary cycle skips the shadow wait.
    if (load) begin
      shd_val_d = value_in;
      shd_dp_d  = dp_in;
      if (frame_tick) begin
        act_val_d = value_in;
        act_dp_d  = dp_in;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end

    lead = 1'b1;
    supp = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lead    = lead & (act_val_d[4*i +: 4] == 4'h0);
      supp[i] = lead;
    end

    // Outputs are computed from next-state so the registers line up with the state.
    bcd_d  = act_val_d[{digit_d, 2'b00} +: 4];
    dp_n_d = ~act_dp_d[digit_d];
    an_n_d = '1;
    if (state_d == IDLE) begin
      bcd_d  = 4'hF;
      dp_n_d = 1'b1;
    end else if (lz_suppress && supp[digit_d]) begin
      bcd_d = 4'hF;
    end
    if (state_d == ON) an_n_d[digit_d] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      digit_q    <= '0;
      cnt_q      <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      shd_val_q  <= '0;
      shd_dp_q   <= '0;
      pending_q  <= 1'b0;
      bcd_out    <= 4'hF;
      an_n       <= '1;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      cnt_q      <= cnt_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      shd_val_q  <= shd_val_d;
      shd_dp_q   <= shd_dp_d;
      pending_q  <= pending_d;
      bcd_out    <= bcd_d;
      an_n       <= an_n_d;
      dp_n       <= dp_n_d;
      frame_tick <= frame_tick_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with 4 digits, 8-cycle slots, 2 blank cycles.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        lz_suppress;
  logic [3:0]  bcd_out;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_tick;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  display_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .lz_suppress(lz_suppress),
    .bcd_out    (bcd_out),
    .an_n       (an_n),
    .dp_n       (dp_n),
    .frame_tick (frame_tick),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an_n"}, 16'(an_n), 16'hF);
    chk({tag, "_bcd"}, 16'(bcd_out), 16'hF);
    chk({tag, "_dp_n"}, 16'(dp_n), 16'h1);
    chk({tag, "_tick"}, 16'(frame_tick), 16'h0);
  endtask

  // Called at the first BLANK cycle of a slot; leaves the bench at the next slot's first cycle.
  // b0/dp0 are the expected bcd/dp_n in that first cycle, b/dp for the rest of the slot.
  task automatic slot(input int d, input logic [3:0] b, input logic dp, input logic ft,
                      input logic [3:0] b0, input logic dp0);
    logic [3:0] exp_an;
    for (int c = 0; c < 8; c++) begin
      exp_an = 4'hF;
      if (c >= 2) exp_an[d] = 1'b0;
      chk($sformatf("d%0d_c%0d_an_n", d, c), 16'(an_n), 16'(exp_an));
      chk($sformatf("d%0d_c%0d_bcd", d, c), 16'(bcd_out), 16'((c == 0) ? b0 : b));
      chk($sformatf("d%0d_c%0d_dp_n", d, c), 16'(dp_n), 16'((c == 0) ? dp0 : dp));
      chk($sformatf("d%0d_c%0d_tick", d, c), 16'(frame_tick), 16'((c == 0) ? ft : 1'b0));
      tick();
      load = 1'b0;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    value_in = v;
    dp_in    = dp;
    load     = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0;
    value_in = '0; dp_in = '0; lz_suppress = 1'b0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_dark("reset");
      chk("reset_state", 16'(state_dbg), 16'h0);
    end
    rst = 1'b0;

    // Load while disabled, then enable: shows at once
    do_load(16'h1234, 4'b0000);
    tick();
    load = 1'b0;
    chk_dark("idle_after_load");
    enable = 1'b1;
    tick();
    chk("blank_state", 16'(state_dbg), 16'h1);
    slot(0, 4'h4, 1'b1, 1'b0, 4'h4, 1'b1);
    slot(1, 4'h3, 1'b1, 1'b0, 4'h3, 1'b1);
    slot(2, 4'h2, 1'b1, 1'b0, 4'h2, 1'b1);
    slot(3, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1);

    // Mid-frame load waits for the next frame
    slot(0, 4'h4, 1'b1, 1'b1, 4'h4, 1'b1);
    slot(1, 4'h3, 1'b1, 1'b0, 4'h3, 1'b1);
    do_load(16'h5678, 4'b0100);
    slot(2, 4'h2, 1'b1, 1'b0, 4'h2, 1'b1);
    slot(3, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1);
    slot(0, 4'h8, 1'b1, 1'b1, 4'h8, 1'b1);
    slot(1, 4'h7, 1'b1, 1'b0, 4'h7, 1'b1);
    slot(2, 4'h6, 1'b0, 1'b0, 4'h6, 1'b0);
    slot(3, 4'h5, 1'b1, 1'b0, 4'h5, 1'b1);

    // Leading-zero suppression; dp of a blanked digit still lit
    lz_suppress = 1'b1;
    slot(0, 4'h8, 1'b1, 1'b1, 4'h8, 1'b1);
    do_load(16'h0070, 4'b1000);
    slot(1, 4'h7, 1'b1, 1'b0, 4'h7, 1'b1);
    slot(2, 4'h6, 1'b0, 1'b0, 4'h6, 1'b0);
    slot(3, 4'h5, 1'b1, 1'b0, 4'h5, 1'b1);
    slot(0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1);
    do_load(16'h0000, 4'b0000);
    slot(1, 4'h7, 1'b1, 1'b0, 4'h7, 1'b1);
    slot(2, 4'hF, 1'b1, 1'b0, 4'hF, 1'b1);
    slot(3, 4'hF, 1'b0, 1'b0, 4'hF, 1'b0);

    // All-zero value shows only digit 0; load in the frame_tick cycle bypasses
    do_load(16'h0905, 4'b0001);
    slot(0, 4'h5, 1'b0, 1'b1, 4'h0, 1'b1);
    slot(1, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1);
    slot(2, 4'h9, 1'b1, 1'b0, 4'h9, 1'b1);
    slot(3, 4'hF, 1'b1, 1'b0, 4'hF, 1'b1);
    slot(0, 4'h5, 1'b0, 1'b1, 4'h5, 1'b0);

    // Disable while ON, then re-enable from digit 0
    for (int i = 0; i < 3; i++) tick();
    chk("on_an_n", 16'(an_n), 16'hD);
    chk("on_state", 16'(state_dbg), 16'h2);
    enable = 1'b0;
    tick();
    chk_dark("disable");
    chk("disable_state", 16'(state_dbg), 16'h0);
    tick();
    chk_dark("disable_hold");
    enable = 1'b1;
    tick();
    slot(0, 4'h5, 1'b0, 1'b0, 4'h5, 1'b0);
    slot(1, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1);

    // Reset mid-ON
    for (int i = 0; i < 3; i++) tick();
    chk("pre_rst_an_n", 16'(an_n), 16'hB);
    rst = 1'b1;
    tick();
    chk_dark("rst_mid_on");
    chk("rst_mid_on_state", 16'(state_dbg), 16'h0);
    rst = 1'b0;
    enable = 1'b0;
    tick();
    chk_dark("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
